// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, load type codes and writeback state encoding
package mips_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_WRITE} wb_state_e;
endpackage

// File: rtl/load_extract.sv
// load_extract: little-endian byte/half lane select with sign or zero extension
module load_extract
  import mips_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] rdata,
  input  logic [2:0]    load_type,
  input  logic [1:0]    addr_lo,
  output logic [DW-1:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[8*addr_lo +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result = load_type == LT_LB  ? {{24{b[7]}}, b} :
             load_type == LT_LBU ? {24'd0, b} :
             load_type == LT_LH  ? {{16{h[15]}}, h} :
             load_type == LT_LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback FSM driving one registered register-file write per retiring instruction
module wb_stage
  import mips_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_reg_write,
  input  logic          in_mem_to_reg,
  input  logic [2:0]    in_load_type,
  input  logic [1:0]    in_addr_lo,
  input  logic [AW-1:0] in_dest,
  input  logic [DW-1:0] in_alu_result,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          busy,
  output logic          proto_err
);
  wb_state_e     state_q, state_d;
  logic [AW-1:0] dest_q, dest_d, rf_waddr_q, rf_waddr_d;
  logic [2:0]    lt_q, lt_d;
  logic [1:0]    lo_q, lo_d;
  logic          wr_en_q, wr_en_d, rf_we_q, rf_we_d, busy_q, busy_d, proto_err_q, proto_err_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d, ext_data;
  logic          accept, dest_nz;
  load_extract #(.DW(DW)) u_ext (
    .rdata(mem_rdata), .load_type(lt_q), .addr_lo(lo_q), .result(ext_data)
  );
  assign in_ready = state_q != S_WAIT_MEM;
  assign accept = in_valid && in_ready;
  assign dest_nz = in_dest != '0;
  always_comb begin
    state_d = S_IDLE;
    dest_d = dest_q;
    lt_d = lt_q;
    lo_d = lo_q;
    wr_en_d = wr_en_q;
    rf_we_d = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    proto_err_d = proto_err_q || (mem_rvalid && state_q != S_WAIT_MEM);
    if (state_q == S_WAIT_MEM) begin
      state_d = !mem_rvalid ? S_WAIT_MEM : wr_en_q ? S_WRITE : S_IDLE;
      rf_we_d = mem_rvalid && wr_en_q;
      rf_waddr_d = rf_we_d ? dest_q : rf_waddr_q;
      rf_wdata_d = rf_we_d ? ext_data : rf_wdata_q;
    end else if (accept && in_mem_to_reg) begin
      state_d = S_WAIT_MEM;
      dest_d = in_dest;
      lt_d = in_load_type;
      lo_d = in_addr_lo;
      wr_en_d = in_reg_write && dest_nz;
    end else if (accept && in_reg_write && dest_nz) begin
      state_d = S_WRITE;
      rf_we_d = 1'b1;
      rf_waddr_d = in_dest;
      rf_wdata_d = in_alu_result;
    end
    busy_d = state_d == S_WAIT_MEM;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dest_q <= '0;
      lt_q <= '0;
      lo_q <= '0;
      wr_en_q <= 1'b0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      lt_q <= lt_d;
      lo_q <= lo_d;
      wr_en_q <= wr_en_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q <= busy_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy = busy_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scenario tasks plus randomized ops against a behavioural writeback model
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_reg_write, in_mem_to_reg, mem_rvalid;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic [4:0]  in_dest, rf_waddr;
  logic [31:0] in_alu_result, mem_rdata, rf_wdata;
  logic        rf_we, busy, proto_err;
  int errors = 0;
  int checks = 0;
  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .in_addr_lo(in_addr_lo), .in_dest(in_dest), .in_alu_result(in_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .busy(busy), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_load(input int lt, input int lo, input logic [31:0] w);
    longint v;
    if (lt == 1 || lt == 2) begin
      v = (longint'(w) >> (8 * lo)) % 256;
      if (lt == 1 && v >= 128) v = v - 256;
    end else if (lt == 3 || lt == 4) begin
      v = (longint'(w) >> (16 * (lo / 2))) % 65536;
      if (lt == 3 && v >= 32768) v = v - 65536;
    end else v = longint'(w);
    return v[31:0];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_op(input logic rw, input logic m2r, input logic [2:0] lt, input logic [1:0] lo,
                          input logic [4:0] d, input logic [31:0] alu);
    in_valid = 1'b1; in_reg_write = rw; in_mem_to_reg = m2r; in_load_type = lt;
    in_addr_lo = lo; in_dest = d; in_alu_result = alu;
  endtask
  task automatic do_reset;
    reset = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    in_reg_write = 0; in_mem_to_reg = 0; in_load_type = 0; in_addr_lo = 0; in_dest = 0;
    in_alu_result = 0; mem_rdata = 0;
    do_reset;
    checks++; if ({rf_we, busy, proto_err, in_ready} !== 4'b0001) begin errors++; $display("FAIL reset_flags got=%b want=0001", {rf_we, busy, proto_err, in_ready}); end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_data got=%0d/%h want=0/0", rf_waddr, rf_wdata); end
  endtask
  task automatic test_alu;
    drive_op(1, 0, 0, 0, 5, 32'h1234_5678);
    tick;
    in_valid = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_write got=%b/%0d/%h want=1/5/12345678", rf_we, rf_waddr, rf_wdata); end
    tick;
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_hold got=%b/%0d/%h want=0/5/12345678", rf_we, rf_waddr, rf_wdata); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] v;
    for (int i = 1; i <= 3; i++) begin
      v = $urandom;
      drive_op(1, 0, 0, 0, 5'(i), v);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b want=1", i, in_ready); end
      tick;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== v) begin errors++; $display("FAIL b2b_write%0d got=%b/%0d/%h want=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, i, v); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b want=0", rf_we); end
  endtask
  task automatic run_load(input logic [2:0] lt, input logic [1:0] lo, input logic [4:0] d,
                          input logic [31:0] w, input int gap, input logic rw);
    logic [31:0] exp_d;
    logic exp_we;
    logic [4:0] prev_a;
    logic [31:0] prev_d;
    exp_we = rw && d != 0;
    exp_d = ref_load(int'(lt), int'(lo), w);
    prev_a = rf_waddr; prev_d = rf_wdata;
    drive_op(rw, 1, lt, lo, d, $urandom);
    tick;
    in_valid = 1'b0;
    for (int k = 1; k < gap; k++) begin
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL load_wait got=%b%b%b want=011", in_ready, busy, rf_we); end
      tick;
    end
    mem_rvalid = 1'b1; mem_rdata = w;
    tick;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    checks++; if (rf_we !== exp_we || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL load_done got=%b%b%b want=%b01", rf_we, busy, in_ready, exp_we); end
    checks++; if (rf_waddr !== (exp_we ? d : prev_a) || rf_wdata !== (exp_we ? exp_d : prev_d)) begin errors++; $display("FAIL load_data lt=%0d lo=%0d got=%0d/%h want=%0d/%h", lt, lo, rf_waddr, rf_wdata, exp_we ? d : prev_a, exp_we ? exp_d : prev_d); end
  endtask
  task automatic test_loads;
    run_load(3'd1, 2'd2, 5'd7, 32'h0080_FF11, 3, 1);
    run_load(3'd2, 2'd1, 5'd8, 32'h0080_FF11, 3, 1);
    run_load(3'd3, 2'd3, 5'd9, 32'h0080_FF11, 3, 1);
    run_load(3'd1, 2'd1, 5'd10, 32'h0080_FF11, 3, 1);
    tick;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL load_single got=%b want=0", rf_we); end
  endtask
  task automatic test_dest0;
    drive_op(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    tick;
    in_valid = 1'b0;
    checks++; if (rf_we !== 1'b0 || rf_wdata === 32'hDEAD_BEEF) begin errors++; $display("FAIL dest0_alu got=%b/%h want=0/not deadbeef", rf_we, rf_wdata); end
    run_load(3'd0, 2'd0, 5'd0, 32'hCAFE_F00D, 2, 1);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL dest0_proto got=%b want=0", proto_err); end
  endtask
  task automatic test_random;
    logic [2:0] lt;
    logic [4:0] d;
    logic [31:0] v;
    logic rw;
    int pa;
    logic [31:0] pd;
    for (int n = 0; n < 60; n++) begin
      lt = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rw = $urandom_range(0, 4) != 0;
      v = $urandom;
      if ($urandom_range(0, 1) == 1) run_load(lt, 2'($urandom), d, $urandom, $urandom_range(1, 4), rw);
      else begin
        pa = int'(rf_waddr); pd = rf_wdata;
        drive_op(rw, 0, lt, 2'($urandom), d, v);
        tick;
        in_valid = 1'b0;
        if (rw && d != 0) begin
          checks++; if (rf_we !== 1'b1 || rf_waddr !== d || rf_wdata !== v) begin errors++; $display("FAIL rnd_alu got=%b/%0d/%h want=1/%0d/%h", rf_we, rf_waddr, rf_wdata, d, v); end
        end else begin
          checks++; if (rf_we !== 1'b0 || int'(rf_waddr) != pa || rf_wdata !== pd) begin errors++; $display("FAIL rnd_nowrite got=%b/%0d/%h want=0/%0d/%h", rf_we, rf_waddr, rf_wdata, pa, pd); end
        end
      end
    end
    tick;
    checks++; if (proto_err !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL rnd_end got=%b%b want=00", proto_err, rf_we); end
  endtask
  task automatic test_reset_mid;
    drive_op(1, 1, 0, 0, 5'd12, 0);
    tick;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got=%b%b%b want=001", rf_we, busy, in_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick;
    mem_rvalid = 1'b0;
    checks++; if (proto_err !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL mid_late got=%b%b want=10", proto_err, rf_we); end
    tick;
    checks++; if (rf_we !== 1'b0 || rf_wdata === 32'h1111_2222) begin errors++; $display("FAIL mid_nowrite got=%b/%h want=0/not 11112222", rf_we, rf_wdata); end
  endtask
  task automatic test_stray;
    do_reset;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL stray_clear got=%b want=0", proto_err); end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick;
    mem_rvalid = 1'b0;
    checks++; if (proto_err !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL stray_set got=%b%b want=10", proto_err, rf_we); end
    for (int i = 0; i < 3; i++) begin
      drive_op(1, 0, 0, 0, 5'd20, 32'(i));
      tick;
    end
    in_valid = 1'b0;
    tick;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL stray_sticky got=%b want=1", proto_err); end
  endtask
  initial begin
    in_valid = 1'b0; mem_rvalid = 1'b0; reset = 1'b1;
    test_reset;
    test_alu;
    test_back_to_back;
    test_loads;
    test_dest0;
    test_random;
    test_reset_mid;
    test_stray;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
